// File: rtl/btndebounce.sv
// Debounces up to eight PMod button lines and reports stable levels, edge
// pulses and write-one-to-clear press/release latches over Wishbone.
module btndebounce #(
    parameter int NBTN     = 8,
    parameter int DEBOUNCE = 50000,
    parameter int CTRBITS  = $clog2(DEBOUNCE) + 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NBTN-1:0] i_btn,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [31:0]     i_wb_data,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic [31:0]     o_wb_data,
    output logic [NBTN-1:0] o_btn,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic            o_int
);

    localparam logic [CTRBITS-1:0] CTR_MAX = CTRBITS'(DEBOUNCE - 1);

    logic [NBTN-1:0]    s1;
    logic [NBTN-1:0]    s2;
    logic [CTRBITS-1:0] ctr [NBTN];
    logic [NBTN-1:0]    flip;
    logic [NBTN-1:0]    press_set;
    logic [NBTN-1:0]    release_set;
    logic [NBTN-1:0]    press_clr;
    logic [NBTN-1:0]    release_clr;
    logic [NBTN-1:0]    press_latch;
    logic [NBTN-1:0]    release_latch;
    logic [31:0]        rd_word;
    logic               wr_en;
    logic               unused_bits;

    assign o_wb_stall  = 1'b0;
    assign unused_bits = ^{i_wb_cyc, i_wb_data};

    // A line flips when it has disagreed with the stable level for DEBOUNCE
    // consecutive synchronized samples.
    always_comb begin
        flip = '0;
        for (int k = 0; k < NBTN; k++) begin
            flip[k] = (s2[k] != o_btn[k]) && (ctr[k] == CTR_MAX);
        end
    end

    assign press_set   = flip & s2;
    assign release_set = flip & ~s2;
    assign wr_en       = i_wb_stb & i_wb_we;
    assign press_clr   = wr_en ? i_wb_data[8 +: NBTN]  : '0;
    assign release_clr = wr_en ? i_wb_data[16 +: NBTN] : '0;
    assign o_int       = (|press_latch) | (|release_latch);

    always_comb begin
        rd_word = '0;
        rd_word[NBTN-1:0]   = o_btn;
        rd_word[8 +: NBTN]  = press_latch;
        rd_word[16 +: NBTN] = release_latch;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1 <= '0;
            s2 <= '0;
            for (int k = 0; k < NBTN; k++) begin
                ctr[k] <= '0;
            end
        end else begin
            s1 <= i_btn;
            s2 <= s1;
            for (int k = 0; k < NBTN; k++) begin
                if ((s2[k] == o_btn[k]) || (ctr[k] == CTR_MAX)) begin
                    ctr[k] <= '0;
                end else begin
                    ctr[k] <= ctr[k] + CTRBITS'(1);
                end
            end
        end
    end

    // Set has priority over a same-cycle clear so no event is ever lost.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_btn         <= '0;
            o_press       <= '0;
            o_release     <= '0;
            press_latch   <= '0;
            release_latch <= '0;
        end else begin
            o_btn         <= o_btn ^ flip;
            o_press       <= press_set;
            o_release     <= release_set;
            press_latch   <= (press_latch & ~press_clr) | press_set;
            release_latch <= (release_latch & ~release_clr) | release_set;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= i_wb_stb;
            if (i_wb_stb) begin
                o_wb_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_btndebounce.sv
// Directed test of btndebounce with DEBOUNCE=4: timing, glitch rejection,
// latch set/clear priority, bus reads/writes and reset behaviour.
module tb_btndebounce;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_btn;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_data;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;
    logic [7:0]  o_btn;
    logic [7:0]  o_press;
    logic [7:0]  o_release;
    logic        o_int;

    int total = 0;
    int bad   = 0;

    btndebounce #(.NBTN(8), .DEBOUNCE(4)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_btn      (i_btn),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_data  (i_wb_data),
        .o_wb_stall (o_wb_stall),
        .o_wb_ack   (o_wb_ack),
        .o_wb_data  (o_wb_data),
        .o_btn      (o_btn),
        .o_press    (o_press),
        .o_release  (o_release),
        .o_int      (o_int)
    );

    always #5 i_clk = ~i_clk;

    // Advance n clock edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] btn);
        i_btn = btn;
    endtask

    task automatic readWord(input string tag, input logic [31:0] expected);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = 1'b0;
        tick(1);
        checkOutput({tag, "_ack"}, {31'h0, o_wb_ack}, 32'h1);
        checkOutput({tag, "_data"}, o_wb_data, expected);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        tick(1);
        checkOutput({tag, "_ackdrop"}, {31'h0, o_wb_ack}, 32'h0);
    endtask

    task automatic writeWord(input string tag, input logic [31:0] wdata,
                             input logic [31:0] expected_pre);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b1;
        i_wb_data = wdata;
        tick(1);
        checkOutput({tag, "_ack"}, {31'h0, o_wb_ack}, 32'h1);
        checkOutput({tag, "_pre"}, o_wb_data, expected_pre);
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_data = 32'h0;
    endtask

    initial begin
        i_reset   = 1'b1;
        i_btn     = 8'h00;
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_data = 32'h0;
        tick(2);
        i_reset = 1'b0;

        checkOutput("rst_btn", {24'h0, o_btn}, 32'h0);
        checkOutput("rst_press", {24'h0, o_press}, 32'h0);
        checkOutput("rst_release", {24'h0, o_release}, 32'h0);
        checkOutput("rst_int", {31'h0, o_int}, 32'h0);
        checkOutput("rst_ack", {31'h0, o_wb_ack}, 32'h0);
        checkOutput("rst_stall", {31'h0, o_wb_stall}, 32'h0);
        readWord("rst_read", 32'h0);

        // Three-cycle glitch on line 0 must be rejected.
        applyStimulus(8'h01);
        tick(3);
        applyStimulus(8'h00);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checkOutput("glitch_btn", {24'h0, o_btn}, 32'h0);
            checkOutput("glitch_press", {24'h0, o_press}, 32'h0);
        end
        checkOutput("glitch_int", {31'h0, o_int}, 32'h0);

        applyStimulus(8'h01);
        tick(5);
        checkOutput("hold0_early", {24'h0, o_btn}, 32'h0);
        tick(1);
        checkOutput("hold0_btn", {24'h0, o_btn}, 32'h01);
        checkOutput("hold0_press", {24'h0, o_press}, 32'h01);
        checkOutput("hold0_int", {31'h0, o_int}, 32'h1);
        tick(1);
        checkOutput("hold0_pulse_end", {24'h0, o_press}, 32'h0);

        applyStimulus(8'h00);
        tick(5);
        checkOutput("rel0_early", {24'h0, o_btn}, 32'h01);
        tick(1);
        checkOutput("rel0_btn", {24'h0, o_btn}, 32'h0);
        checkOutput("rel0_release", {24'h0, o_release}, 32'h01);
        tick(1);
        checkOutput("rel0_pulse_end", {24'h0, o_release}, 32'h0);
        readWord("rel0_read", 32'h0001_0100);
        writeWord("rel0_clr", 32'h0001_0100, 32'h0001_0100);
        checkOutput("rel0_clr_int", {31'h0, o_int}, 32'h0);
        tick(1);
        readWord("rel0_after", 32'h0);

        // Press on line 2 with exact latency.
        applyStimulus(8'h04);
        tick(5);
        checkOutput("p2_early_btn", {24'h0, o_btn}, 32'h0);
        checkOutput("p2_early_press", {24'h0, o_press}, 32'h0);
        tick(1);
        checkOutput("p2_btn", {24'h0, o_btn}, 32'h04);
        checkOutput("p2_press", {24'h0, o_press}, 32'h04);
        checkOutput("p2_int", {31'h0, o_int}, 32'h1);
        tick(1);
        checkOutput("p2_pulse_end", {24'h0, o_press}, 32'h0);
        readWord("p2_read", 32'h0000_0404);

        applyStimulus(8'h00);
        tick(6);
        checkOutput("r2_release", {24'h0, o_release}, 32'h04);
        checkOutput("r2_btn", {24'h0, o_btn}, 32'h0);
        tick(1);
        readWord("r2_read", 32'h0004_0400);
        writeWord("r2_clr", 32'h0004_0400, 32'h0004_0400);
        checkOutput("r2_clr_int", {31'h0, o_int}, 32'h0);
        tick(1);
        readWord("r2_after", 32'h0);

        // Clear of press bit 5 on the very edge the press registers.
        applyStimulus(8'h20);
        tick(5);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b1;
        i_wb_data = 32'h0000_2000;
        tick(1);
        checkOutput("sw_press", {24'h0, o_press}, 32'h20);
        checkOutput("sw_ack", {31'h0, o_wb_ack}, 32'h1);
        checkOutput("sw_pre", o_wb_data, 32'h0);
        checkOutput("sw_int", {31'h0, o_int}, 32'h1);
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_data = 32'h0;
        tick(1);
        readWord("sw_read", 32'h0000_2020);

        // Reset mid-count with line 7 (and line 5) held high.
        applyStimulus(8'hA0);
        tick(3);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        checkOutput("mr_btn", {24'h0, o_btn}, 32'h0);
        checkOutput("mr_int", {31'h0, o_int}, 32'h0);
        checkOutput("mr_data", o_wb_data, 32'h0);
        tick(5);
        checkOutput("mr_early_press", {24'h0, o_press}, 32'h0);
        tick(1);
        checkOutput("mr_press", {24'h0, o_press}, 32'hA0);
        checkOutput("mr_btn_after", {24'h0, o_btn}, 32'hA0);
        checkOutput("mr_int_after", {31'h0, o_int}, 32'h1);
        tick(1);
        checkOutput("mr_pulse_end", {24'h0, o_press}, 32'h0);
        readWord("mr_read", 32'h0000_A0A0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btndebounce.md
# btndebounce

Input-side companion to the PMod LED driver: reads up to eight mechanical buttons or switches on a PMod header, synchronizes and debounces each line, and reports stable levels plus press/release events. Events are latched into a Wishbone-readable status word with write-one-to-clear semantics, and an interrupt line is raised while any event is pending. The block sits on the ZipCPU peripheral bus next to the LED driver.

## Interface
- NBTN, 8: number of input lines, 1..8.
- DEBOUNCE, 50000: consecutive cycles a synchronized input must differ from the stable level before the stable level flips; must be at least 1.
- CTRBITS, $clog2(DEBOUNCE)+1: per-line counter width; must hold DEBOUNCE-1.

- i_clk  input  1  system clock; the only clock.
- i_reset  input  1  synchronous, active-high reset.
- i_btn  input  NBTN  raw asynchronous PMod pins, active-high.
- i_wb_cyc  input  1  Wishbone cycle.
- i_wb_stb  input  1  Wishbone strobe.
- i_wb_we  input  1  write enable.
- i_wb_data  input  32  write data.
- o_wb_stall  output  1  tied 0.
- o_wb_ack  output  1  acknowledge.
- o_wb_data  output  32  read data.
- o_btn  output  NBTN  debounced stable levels.
- o_press  output  NBTN  one-cycle pulse on a stable 0->1 transition.
- o_release  output  NBTN  one-cycle pulse on a stable 1->0 transition.
- o_int  output  1  high while any press or release latch bit is set.

## Operation
- Each line passes through a two-flop synchronizer (s1, s2); logic acts only on s2.
- Per line k: if s2[k] == o_btn[k], ctr[k] <= 0. Otherwise, if ctr[k] == DEBOUNCE-1, o_btn[k] <= s2[k] and ctr[k] <= 0; else ctr[k] <= ctr[k]+1.
- A glitch whose synchronized width is shorter than DEBOUNCE cycles never changes o_btn; the counter restarts from 0 on every return to the stable level.
- Each flip of o_btn[k] registers o_press[k] (0->1) or o_release[k] (1->0) high for exactly that one cycle and sets press_latch[k] or release_latch[k].
- o_int = |press_latch | |release_latch.
- Read word: bits [NBTN-1:0] = o_btn; [8+NBTN-1:8] = press_latch; [16+NBTN-1:16] = release_latch; all other bits 0.
- Write, on i_wb_stb & i_wb_we: each 1 in i_wb_data[15:8] clears the corresponding press_latch bit; each 1 in [23:16] clears the release_latch bit; all other bits are ignored. o_btn is not writable.
- A new event and a clear on the same bit in the same cycle: the set wins and the bit stays 1.
- Lines are independent. Simultaneous events on several lines are all latched.

## Timing
- Reset: s1, s2, o_btn, ctr, press/release latches, o_press, o_release, o_wb_ack and o_wb_data all become 0; o_int is 0 on the following cycle. Reset mid-debounce discards the count.
- A line that is high through a reset is treated as a fresh 0->1 change once reset deasserts, and produces a press event.
- Latency: if a new input level is first sampled by s1 at edge E and then held, o_btn, the event pulse and the latch bit all update at edge E+DEBOUNCE+1.
- o_int rises on the same edge the latch bit sets, and falls on the edge a write clears the last pending bit.
- Bus: o_wb_ack <= i_wb_stb & !i_reset, giving a fixed single-cycle latency with no stalls.
- o_wb_data is registered at the strobe edge and reflects the state from before that cycle's write takes effect.
- o_wb_ack is not gated by i_wb_cyc; the bus master must not raise stb without cyc.

## Test plan
- Reset with DEBOUNCE=4 and i_btn=8'h00 -> o_btn=0, no pulses, o_int=0; reading returns 32'h0 with ack exactly one cycle after stb.
- Step i_btn[2] 0->1, sampled at edge E -> o_btn[2] and o_press[2] rise at E+5; o_press[2] is high for one cycle; read returns 32'h0000_0404; o_int=1.
- 3-cycle high glitch on i_btn[0] (DEBOUNCE=4) -> o_btn[0] stays 0, no pulse, no latch bit; a subsequent 4-cycle-or-longer hold does flip it.
- Release i_btn[2] after the press -> o_release[2] pulses; read returns 32'h0004_0400; write 32'h0004_0400 -> next read returns 32'h0, o_int=0.
- Clear-write to press bit 5 on the same edge a new press on line 5 registers -> press_latch[5] stays 1 and o_int stays 1.
- Assert i_reset for one cycle mid-count while i_btn[7] is held high -> all state clears; o_press[7] pulses 6 cycles after reset deasserts (DEBOUNCE=4).
